// File: rtl/mem_block_buffer_pkg.sv
// Shared types and sizing helpers for the memory block transfer buffer.
// The defaults here match the top-level parameter defaults.
package mem_block_buffer_pkg;

    localparam int DEF_BW_BLOCK     = 2;
    localparam int DEF_BW_WORD_ADDR = 24;
    localparam int DEF_N_WORDS      = 1 << DEF_BW_BLOCK;
    localparam int DEF_BW_CNT       = DEF_BW_BLOCK + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WFILL,
        ST_WCMD,
        ST_WDRAIN,
        ST_RCMD,
        ST_RFILL,
        ST_RDRAIN
    } state_t;

    function automatic int block_words(input int bw_block);
        return 1 << bw_block;
    endfunction

    // The index counter needs one extra bit so it can hold a full block length.
    function automatic int cnt_width(input int bw_block);
        return bw_block + 1;
    endfunction

endpackage

// File: rtl/mem_block_buffer_if.sv
// Cache-side and external-side channels of the block buffer, grouped in one bundle.
// The buffer uses the slave view; the cache/memory environment uses the master view.
interface mem_block_buffer_if #(
    parameter int BW_WORD_ADDR = 24
);
    logic                    cache_req_i;
    logic                    cache_req_block_i;
    logic                    cache_rw_i;
    logic [BW_WORD_ADDR-1:0] cache_add_i;
    logic                    cache_write_i;
    logic [31:0]             cache_data_i;
    logic                    cache_read_i;
    logic                    cache_ready_req_o;
    logic                    cache_ready_write_o;
    logic                    cache_ready_read_o;
    logic [31:0]             cache_data_o;
    logic                    ext_cmd_valid_o;
    logic                    ext_cmd_ready_i;
    logic                    ext_cmd_rw_o;
    logic [BW_WORD_ADDR-1:0] ext_cmd_add_o;
    logic                    ext_cmd_block_o;
    logic                    ext_wdata_valid_o;
    logic                    ext_wdata_ready_i;
    logic [31:0]             ext_wdata_o;
    logic                    ext_rdata_valid_i;
    logic [31:0]             ext_rdata_i;
    logic                    error_o;

    modport slave (
        input  cache_req_i, cache_req_block_i, cache_rw_i, cache_add_i,
        input  cache_write_i, cache_data_i, cache_read_i,
        output cache_ready_req_o, cache_ready_write_o, cache_ready_read_o, cache_data_o,
        output ext_cmd_valid_o, ext_cmd_rw_o, ext_cmd_add_o, ext_cmd_block_o,
        input  ext_cmd_ready_i,
        output ext_wdata_valid_o, ext_wdata_o,
        input  ext_wdata_ready_i,
        input  ext_rdata_valid_i, ext_rdata_i,
        output error_o
    );

    modport master (
        output cache_req_i, cache_req_block_i, cache_rw_i, cache_add_i,
        output cache_write_i, cache_data_i, cache_read_i,
        input  cache_ready_req_o, cache_ready_write_o, cache_ready_read_o, cache_data_o,
        input  ext_cmd_valid_o, ext_cmd_rw_o, ext_cmd_add_o, ext_cmd_block_o,
        output ext_cmd_ready_i,
        input  ext_wdata_valid_o, ext_wdata_o,
        output ext_wdata_ready_i,
        output ext_rdata_valid_i, ext_rdata_i,
        input  error_o
    );
endinterface

// File: rtl/mem_block_buffer_word_store.sv
// N x 32 word store for one block: single indexed write port, asynchronous indexed read.
// Contents are deliberately not reset; the transfer index decides what is valid.
module buffer_word_store #(
    parameter int BW_INDEX = 2
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [BW_INDEX-1:0] i_wr_idx,
    input  logic [31:0]         i_wr_data,
    input  logic [BW_INDEX-1:0] i_rd_idx,
    output logic [31:0]         o_rd_data
);
    localparam int N_WORDS = 1 << BW_INDEX;

    logic [31:0] w_words [N_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi++) begin : g_word
            logic [31:0] r_word;
            always_ff @(posedge clk) begin
                if (i_wr_en && (i_wr_idx == BW_INDEX'(gi))) begin
                    r_word <= i_wr_data;
                end
            end
            assign w_words[gi] = r_word;
        end
    endgenerate

    assign o_rd_data = w_words[i_rd_idx];

endmodule

// File: rtl/mem_block_buffer.sv
// Block transfer buffer between a cache memory port and external command/data channels.
// Collects a whole write-back before issuing it, and a whole fill before handing it over.
module mem_block_buffer
    import mem_block_buffer_pkg::*;
#(
    parameter int BW_BLOCK     = DEF_BW_BLOCK,
    parameter int BW_WORD_ADDR = DEF_BW_WORD_ADDR
) (
    input  logic               clock_i,
    input  logic               reset_i,
    mem_block_buffer_if.slave  bus
);
    localparam int N_WORDS = block_words(BW_BLOCK);
    localparam int BW_CNT  = cnt_width(BW_BLOCK);
    localparam logic [BW_CNT-1:0] LEN_BLOCK = BW_CNT'(N_WORDS);
    localparam logic [BW_CNT-1:0] LEN_WORD  = BW_CNT'(1);

    state_t                  r_state;
    logic [BW_CNT-1:0]       r_idx;
    logic [BW_CNT-1:0]       r_len;
    logic                    r_rw;
    logic                    r_block;
    logic [BW_WORD_ADDR-1:0] r_add;
    logic                    r_error;
    logic [31:0]             r_rdata_hold;
    logic [31:0]             r_wdata_hold;

    logic                    w_last;
    logic                    w_wr_en;
    logic [31:0]             w_wr_data;
    logic [31:0]             w_rd_word;

    assign w_last    = (r_idx == (r_len - LEN_WORD));
    assign w_wr_en   = ((r_state == ST_WFILL) && bus.cache_write_i) ||
                       ((r_state == ST_RFILL) && bus.ext_rdata_valid_i);
    assign w_wr_data = (r_state == ST_WFILL) ? bus.cache_data_i : bus.ext_rdata_i;

    buffer_word_store #(
        .BW_INDEX (BW_BLOCK)
    ) u_store (
        .clk       (clock_i),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx[BW_BLOCK-1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_idx  (r_idx[BW_BLOCK-1:0]),
        .o_rd_data (w_rd_word)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_rw         <= 1'b0;
            r_block      <= 1'b0;
            r_add        <= '0;
            r_error      <= 1'b0;
            r_rdata_hold <= '0;
            r_wdata_hold <= '0;
        end else begin
            // Read beats are unthrottled, so one arriving outside a fill is a lost word.
            if (bus.ext_rdata_valid_i && (r_state != ST_RFILL)) begin
                r_error <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.cache_req_i) begin
                        r_rw    <= bus.cache_rw_i;
                        r_block <= bus.cache_req_block_i;
                        r_len   <= bus.cache_req_block_i ? LEN_BLOCK : LEN_WORD;
                        r_add   <= bus.cache_req_block_i
                                   ? {bus.cache_add_i[BW_WORD_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}}
                                   : bus.cache_add_i;
                        r_idx   <= '0;
                        r_state <= bus.cache_rw_i ? ST_WFILL : ST_RCMD;
                    end
                end
                ST_WFILL: begin
                    if (bus.cache_write_i) begin
                        r_idx   <= w_last ? '0 : r_idx + 1'b1;
                        r_state <= w_last ? ST_WCMD : ST_WFILL;
                    end
                end
                ST_WCMD: begin
                    if (bus.ext_cmd_ready_i) begin
                        r_idx   <= '0;
                        r_state <= ST_WDRAIN;
                    end
                end
                ST_WDRAIN: begin
                    r_wdata_hold <= w_rd_word;
                    if (bus.ext_wdata_ready_i) begin
                        r_idx   <= w_last ? '0 : r_idx + 1'b1;
                        r_state <= w_last ? ST_IDLE : ST_WDRAIN;
                    end
                end
                ST_RCMD: begin
                    if (bus.ext_cmd_ready_i) begin
                        r_idx   <= '0;
                        r_state <= ST_RFILL;
                    end
                end
                ST_RFILL: begin
                    if (bus.ext_rdata_valid_i) begin
                        r_idx   <= w_last ? '0 : r_idx + 1'b1;
                        r_state <= w_last ? ST_RDRAIN : ST_RFILL;
                    end
                end
                ST_RDRAIN: begin
                    // Track the presented word so the output holds it once the drain ends.
                    r_rdata_hold <= w_rd_word;
                    if (bus.cache_read_i) begin
                        r_idx   <= w_last ? '0 : r_idx + 1'b1;
                        r_state <= w_last ? ST_IDLE : ST_RDRAIN;
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cache_ready_req_o   = (r_state == ST_IDLE) && !reset_i;
    assign bus.cache_ready_write_o = (r_state == ST_WFILL);
    assign bus.cache_ready_read_o  = (r_state == ST_RDRAIN);
    assign bus.cache_data_o        = (r_state == ST_RDRAIN) ? w_rd_word : r_rdata_hold;
    assign bus.ext_cmd_valid_o     = (r_state == ST_WCMD) || (r_state == ST_RCMD);
    assign bus.ext_cmd_rw_o        = r_rw;
    assign bus.ext_cmd_add_o       = r_add;
    assign bus.ext_cmd_block_o     = r_block;
    assign bus.ext_wdata_valid_o   = (r_state == ST_WDRAIN);
    assign bus.ext_wdata_o         = (r_state == ST_WDRAIN) ? w_rd_word : r_wdata_hold;
    assign bus.error_o             = r_error;

endmodule

// File: tb/tb_mem_block_buffer.sv
// Self-checking bench for mem_block_buffer: directed scenarios followed by random
// transactions, checked against a transaction-level model of the buffer.
module tb_mem_block_buffer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_block_buffer_if #(.BW_WORD_ADDR(24)) bus();

    mem_block_buffer #(
        .BW_BLOCK     (2),
        .BW_WORD_ADDR (24)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] xfer [N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_add(input logic [23:0] a, input bit blk);
        return blk ? (a / 24'(N)) * 24'(N) : a;
    endfunction

    task automatic do_write(input logic [23:0] a, input bit blk, input int gap_max,
                            input bit hold_rd, input logic [23:0] rd_a, input bit rd_blk);
        int len = blk ? N : 1;
        int i;
        int guard;
        bit r;
        chk1("wr_ready_req", bus.cache_ready_req_o, 1'b1);
        bus.cache_req_i = 1'b1; bus.cache_rw_i = 1'b1;
        bus.cache_req_block_i = blk; bus.cache_add_i = a;
        step();
        bus.cache_req_i = 1'b0;
        for (int w = 0; w < len; w++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.cache_read_i = 1'($urandom_range(0, 1));
                bus.cache_req_i  = 1'($urandom_range(0, 1));
                chk1("wfill_ready_write", bus.cache_ready_write_o, 1'b1);
                chk1("wfill_ready_read", bus.cache_ready_read_o, 1'b0);
                step();
                bus.cache_read_i = 1'b0; bus.cache_req_i = 1'b0;
            end
            bus.cache_write_i = 1'b1; bus.cache_data_i = xfer[w];
            bus.cache_read_i  = 1'($urandom_range(0, 1));
            chk1("wfill_ready_write", bus.cache_ready_write_o, 1'b1);
            chk1("wfill_no_cmd", bus.ext_cmd_valid_o, 1'b0);
            step();
            bus.cache_write_i = 1'b0; bus.cache_read_i = 1'b0;
        end
        chk1("wcmd_valid", bus.ext_cmd_valid_o, 1'b1);
        chk1("wcmd_rw", bus.ext_cmd_rw_o, 1'b1);
        chk32("wcmd_add", 32'(bus.ext_cmd_add_o), 32'(exp_add(a, blk)));
        chk1("wcmd_block", bus.ext_cmd_block_o, blk);
        repeat ($urandom_range(0, 3)) begin
            chk1("wcmd_hold", bus.ext_cmd_valid_o, 1'b1);
            chk1("wcmd_no_wdata", bus.ext_wdata_valid_o, 1'b0);
            step();
        end
        bus.ext_cmd_ready_i = 1'b1;
        step();
        bus.ext_cmd_ready_i = 1'b0;
        if (hold_rd) begin
            bus.cache_req_i = 1'b1; bus.cache_rw_i = 1'b0;
            bus.cache_req_block_i = rd_blk; bus.cache_add_i = rd_a;
        end
        i = 0;
        guard = 0;
        while (i < len && guard < 200) begin
            r = 1'($urandom_range(0, 1));
            chk1("wdrain_valid", bus.ext_wdata_valid_o, 1'b1);
            chk32("wdrain_data", bus.ext_wdata_o, xfer[i]);
            chk1("wdrain_no_req", bus.cache_ready_req_o, 1'b0);
            bus.ext_wdata_ready_i = r;
            step();
            bus.ext_wdata_ready_i = 1'b0;
            if (r) i++;
            guard++;
        end
        chk1("wr_done_ready_req", bus.cache_ready_req_o, 1'b1);
        chk1("wr_done_wdata_valid", bus.ext_wdata_valid_o, 1'b0);
        $display("[TB] write add=0x%06h block=%0d words=%0d", a, blk, len);
    endtask

    task automatic do_read(input logic [23:0] a, input bit blk, input int gap_max, input bit pre_req);
        int len = blk ? N : 1;
        chk1("rd_ready_req", bus.cache_ready_req_o, 1'b1);
        if (!pre_req) begin
            bus.cache_req_i = 1'b1; bus.cache_rw_i = 1'b0;
            bus.cache_req_block_i = blk; bus.cache_add_i = a;
        end
        step();
        bus.cache_req_i = 1'b0;
        chk1("rcmd_valid", bus.ext_cmd_valid_o, 1'b1);
        chk1("rcmd_rw", bus.ext_cmd_rw_o, 1'b0);
        chk32("rcmd_add", 32'(bus.ext_cmd_add_o), 32'(exp_add(a, blk)));
        chk1("rcmd_block", bus.ext_cmd_block_o, blk);
        repeat ($urandom_range(0, 3)) step();
        bus.ext_cmd_ready_i = 1'b1;
        step();
        bus.ext_cmd_ready_i = 1'b0;
        for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.cache_write_i = 1'($urandom_range(0, 1));
                bus.cache_data_i  = $urandom;
                bus.cache_read_i  = 1'($urandom_range(0, 1));
                bus.cache_req_i   = 1'($urandom_range(0, 1));
                chk1("rfill_ready_read", bus.cache_ready_read_o, 1'b0);
                step();
                bus.cache_write_i = 1'b0; bus.cache_read_i = 1'b0; bus.cache_req_i = 1'b0;
            end
            bus.ext_rdata_valid_i = 1'b1; bus.ext_rdata_i = xfer[b];
            step();
            bus.ext_rdata_valid_i = 1'b0;
        end
        chk1("rfill_done_ready_read", bus.cache_ready_read_o, 1'b1);
        for (int p = 0; p < len; p++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.cache_write_i = 1'($urandom_range(0, 1));
                bus.cache_data_i  = $urandom;
                chk1("rdrain_ready_read", bus.cache_ready_read_o, 1'b1);
                chk32("rdrain_data_gap", bus.cache_data_o, xfer[p]);
                step();
                bus.cache_write_i = 1'b0;
            end
            bus.cache_read_i  = 1'b1;
            bus.cache_write_i = 1'($urandom_range(0, 1));
            chk32("rdrain_data", bus.cache_data_o, xfer[p]);
            step();
            bus.cache_read_i = 1'b0; bus.cache_write_i = 1'b0;
        end
        chk1("rd_done_ready_req", bus.cache_ready_req_o, 1'b1);
        chk1("rd_done_ready_read", bus.cache_ready_read_o, 1'b0);
        chk32("rd_done_data_hold", bus.cache_data_o, xfer[len-1]);
        $display("[TB] read  add=0x%06h block=%0d words=%0d", a, blk, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.cache_req_i = 1'b0; bus.cache_req_block_i = 1'b0; bus.cache_rw_i = 1'b0;
        bus.cache_add_i = '0; bus.cache_write_i = 1'b0; bus.cache_data_i = '0;
        bus.cache_read_i = 1'b0; bus.ext_cmd_ready_i = 1'b0; bus.ext_wdata_ready_i = 1'b0;
        bus.ext_rdata_valid_i = 1'b0; bus.ext_rdata_i = '0;

        // Reset state
        step();
        chk1("rst_ready_req_forced", bus.cache_ready_req_o, 1'b0);
        chk1("rst_cmd_valid", bus.ext_cmd_valid_o, 1'b0);
        chk1("rst_wdata_valid", bus.ext_wdata_valid_o, 1'b0);
        chk1("rst_ready_read", bus.cache_ready_read_o, 1'b0);
        chk1("rst_ready_write", bus.cache_ready_write_o, 1'b0);
        chk32("rst_data_o", bus.cache_data_o, 32'h0);
        chk32("rst_wdata_o", bus.ext_wdata_o, 32'h0);
        chk1("rst_error", bus.error_o, 1'b0);
        rst = 1'b0;
        step();
        chk1("post_rst_ready_req", bus.cache_ready_req_o, 1'b1);
        $display("[TB] reset checked");

        // Block read, block write, single-word read
        for (int k = 0; k < N; k++) xfer[k] = 32'hA0 + 32'(k);
        do_read(24'h000013, 1'b1, 2, 1'b0);
        for (int k = 0; k < N; k++) xfer[k] = 32'hB0 + 32'(k);
        do_write(24'h000040, 1'b1, 1, 1'b0, 24'h0, 1'b0);
        xfer[0] = 32'hC5;
        do_read(24'h000013, 1'b0, 1, 1'b0);
        chk32("single_read_data", bus.cache_data_o, 32'hC5);

        // Reset during a fill after two beats
        bus.cache_req_i = 1'b1; bus.cache_rw_i = 1'b0;
        bus.cache_req_block_i = 1'b1; bus.cache_add_i = 24'h000020;
        step();
        bus.cache_req_i = 1'b0; bus.ext_cmd_ready_i = 1'b1;
        step();
        bus.ext_cmd_ready_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.ext_rdata_valid_i = 1'b1; bus.ext_rdata_i = 32'hD0 + 32'(b);
            step();
        end
        bus.ext_rdata_valid_i = 1'b0;
        rst = 1'b1;
        chk1("midrst_ready_req_forced", bus.cache_ready_req_o, 1'b0);
        step();
        chk1("midrst_ready_req", bus.cache_ready_req_o, 1'b0);
        chk1("midrst_cmd_valid", bus.ext_cmd_valid_o, 1'b0);
        chk1("midrst_ready_read", bus.cache_ready_read_o, 1'b0);
        chk1("midrst_wdata_valid", bus.ext_wdata_valid_o, 1'b0);
        chk32("midrst_data_o", bus.cache_data_o, 32'h0);
        chk32("midrst_wdata_o", bus.ext_wdata_o, 32'h0);
        rst = 1'b0;
        step();
        chk1("midrst_release_ready_req", bus.cache_ready_req_o, 1'b1);
        $display("[TB] reset during fill checked");
        for (int k = 0; k < N; k++) xfer[k] = 32'hE0 + 32'(k);
        do_read(24'h000027, 1'b1, 1, 1'b0);

        // Write-back with the fill request held throughout the drain
        for (int k = 0; k < N; k++) xfer[k] = 32'hF0 + 32'(k);
        do_write(24'h000101, 1'b1, 1, 1'b1, 24'h000203, 1'b1);
        for (int k = 0; k < N; k++) xfer[k] = 32'h1234_0000 + 32'(k);
        do_read(24'h000203, 1'b1, 1, 1'b1);

        // Stray read beat in IDLE
        chk1("error_clear", bus.error_o, 1'b0);
        bus.ext_rdata_valid_i = 1'b1; bus.ext_rdata_i = 32'hDEAD;
        step();
        bus.ext_rdata_valid_i = 1'b0;
        chk1("error_set", bus.error_o, 1'b1);
        chk1("error_no_state_change", bus.cache_ready_req_o, 1'b1);
        step();
        chk1("error_sticky", bus.error_o, 1'b1);
        $display("[TB] stray read beat checked");

        // Random transactions
        for (int t = 0; t < 24; t++) begin
            bit rw  = 1'($urandom_range(0, 1));
            bit blk = 1'($urandom_range(0, 1));
            logic [23:0] a = 24'($urandom);
            for (int k = 0; k < N; k++) xfer[k] = $urandom;
            if (rw) do_write(a, blk, 2, 1'b0, 24'h0, 1'b0);
            else    do_read(a, blk, 2, 1'b0);
        end
        chk1("error_sticky_end", bus.error_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_block_buffer.md
# mem_block_buffer

Block transfer buffer between a cache controller's memory port and the external memory command/data channels. It accepts one word or one block request from the cache and, for a write-back, collects the block before issuing it externally. For a fill, it collects the whole block from memory before handing it to the cache word by word. It sits directly downstream of each cache instance and provides that cache's `ready_req`, `ready_write`, `ready_read` and `data` inputs.

## Interface
Parameters:
- `BW_BLOCK`, 2: log2 of words per block; N = 2**BW_BLOCK.
- `BW_WORD_ADDR`, 24: word-address width.

Ports:
- `clock_i` in 1: single clock. One clock; reset is synchronous and active-high.
- `reset_i` in 1: synchronous, active-high reset.
- `cache_req_i` in 1: request strobe from the cache.
- `cache_req_block_i` in 1: 1 = N-word block, 0 = single word.
- `cache_rw_i` in 1: 1 = write to memory, 0 = read from memory.
- `cache_add_i` in BW_WORD_ADDR: request word address.
- `cache_write_i` in 1: write-data strobe from the cache.
- `cache_data_i` in 32: write data from the cache.
- `cache_read_i` in 1: read-acknowledge/pop strobe from the cache.
- `cache_ready_req_o` out 1: can accept a request.
- `cache_ready_write_o` out 1: can accept a write word.
- `cache_ready_read_o` out 1: read word available.
- `cache_data_o` out 32: current read word (first-word fall-through).
- `ext_cmd_valid_o` out 1: external command valid.
- `ext_cmd_ready_i` in 1: external command accepted.
- `ext_cmd_rw_o` out 1: external command direction.
- `ext_cmd_add_o` out BW_WORD_ADDR: external start address.
- `ext_cmd_block_o` out 1: external length, 1 = N words.
- `ext_wdata_valid_o` out 1: write beat valid.
- `ext_wdata_ready_i` in 1: write beat accepted.
- `ext_wdata_o` out 32: write beat data.
- `ext_rdata_valid_i` in 1: read beat valid. No backpressure.
- `ext_rdata_i` in 32: read beat data.
- `error_o` out 1: sticky protocol error.

## Operation
- States: IDLE, WFILL, WCMD, WDRAIN, RCMD, RFILL, RDRAIN.
- Length L = N if `cache_req_block_i`, else 1. It is latched together with rw and address when the request is accepted.
- Latched address:
  - Block requests zero the low BW_BLOCK bits.
  - Single-word requests use `cache_add_i` unchanged.
- Word index counter: BW_BLOCK+1 bits, cleared on every state entry. Words are stored and transferred in ascending order from index 0.
- IDLE:
  - `cache_ready_req_o` = 1.
  - A request is accepted when `cache_req_i` is high in IDLE.
  - rw = 1 → WFILL; rw = 0 → RCMD.
- WFILL:
  - `cache_ready_write_o` = 1.
  - Each `cache_write_i` stores `cache_data_i` at the current index.
  - After the L-th word → WCMD.
- WCMD: `ext_cmd_valid_o` = 1 with rw = 1; on `ext_cmd_ready_i` → WDRAIN.
- WDRAIN:
  - `ext_wdata_valid_o` = 1 and `ext_wdata_o` = word[index].
  - Index advances on `ext_wdata_ready_i`.
  - After the L-th handshake → IDLE.
- RCMD: `ext_cmd_valid_o` = 1 with rw = 0; on `ext_cmd_ready_i` → RFILL.
- RFILL: each `ext_rdata_valid_i` stores `ext_rdata_i`; after the L-th beat → RDRAIN.
- RDRAIN:
  - `cache_ready_read_o` = 1 and `cache_data_o` = word[index].
  - `cache_read_i` advances the index.
  - After the L-th pop → IDLE.
- Strobes arriving outside their state are ignored and do not change any state:
  - `cache_req_i` outside IDLE.
  - `cache_write_i` outside WFILL.
  - `cache_read_i` outside RDRAIN.
  - `ext_rdata_valid_i` outside RFILL also sets `error_o`.
- `cache_write_i` together with `cache_read_i` in any state: only the strobe legal for the current state takes effect.
- `cache_data_o` holds its last value outside RDRAIN.

## Timing
- All outputs are decoded from registered state and counter. No input-to-output combinational path exists except the `cache_data_o` mux, which depends on the registered index only.
- Reset:
  - state = IDLE, index = 0, `error_o` = 0, all valid/ready outputs = 0.
  - `cache_ready_req_o` is forced 0 while `reset_i` is high and is 1 in the first cycle after release.
  - `cache_data_o` and `ext_wdata_o` reset to 0.
  - Reset mid-transfer aborts immediately and discards buffered words. No external beat is emitted afterwards.
- Read latency:
  - Request accepted in cycle t → `ext_cmd_valid_o` in t+1.
  - Last rdata beat in cycle k → `cache_ready_read_o` in k+1.
- Write latency:
  - L-th write word in cycle k → `ext_cmd_valid_o` in k+1.
  - Command handshake in cycle c → `ext_wdata_valid_o` in c+1.
- After the last handshake of a transfer, `cache_ready_req_o` is high in the next cycle. A request is accepted at most every 1 + (transfer length) cycles.
- Back-to-back write then read (write-back followed by fill): the read request is accepted only in the cycle after WDRAIN completes. No overlap.

## Structure
- Package `mem_block_buffer_pkg` holds:
  - the state enum;
  - N as a localparam derived from BW_BLOCK;
  - the counter width BW_BLOCK+1.
- Sub-module `buffer_word_store`:
  - N x 32 register array;
  - one write port with index and enable;
  - one asynchronous read port by index.
- Top level contains the FSM, the counter and the address/length latches.

## Test plan
- Block read, BW_BLOCK = 2, add 0x000013:
  - cmd add 0x000010, block = 1.
  - Memory returns 0xA0..0xA3 with gaps.
  - `cache_ready_read_o` rises the cycle after the 4th beat.
  - Four pops yield 0xA0, 0xA1, 0xA2, 0xA3, then `cache_ready_req_o` = 1.
- Block write:
  - Cache writes 0xB0..0xB3 with one idle cycle between words.
  - cmd rw = 1 appears the cycle after 0xB3.
  - With `ext_wdata_ready_i` toggling, beats go out 0xB0..0xB3 in order.
- Single-word read at add 0x000013: cmd add 0x000013, block = 0, one beat 0xC5 → `cache_data_o` = 0xC5; one pop → IDLE.
- Protocol violations:
  - `ext_rdata_valid_i` pulsed in IDLE → `error_o` = 1 and stays 1.
  - `cache_read_i` in WFILL → no state change.
- Reset asserted during RFILL after 2 beats → the next cycle all outputs match reset values; the next read starts at index 0.
- Write-back then fill: `cache_req_i` held with rw = 0 throughout WDRAIN → it is accepted only the cycle after the last wdata handshake.
